solitaire_autoplayer: RTL and testbench
=======================================

SOLITAIRE_AUTOPLAYER -- requirements
Module: solitaire_autoplayer

Interface
REQ-001 Parameter DEPTH, default 16: move buffer entries (power of 2).
REQ-002 Parameter TIMEOUT, default 8: WAIT cycles before a move counts as rejected.
REQ-003 Parameter GAP_CYCLES, default 2: null-move cycles between issued moves.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 wr_valid  in  1  move-write request.
REQ-008 wr_move  in  8  packed move {direction[1:0], y[2:0], x[2:0]}.
REQ-009 wr_ready  out  1  buffer can accept a write this cycle.
REQ-010 start  in  1  single-cycle pulse that begins playback.
REQ-011 clear  in  1  single-cycle pulse: flush buffer, return to IDLE.
REQ-012 piece_x / piece_y / direction  out  3/3/2  move driven into the solitaire game.
REQ-013 piece_count  in  6  game's current peg count.
REQ-014 game_over  in  1  game's end flag.
REQ-015 busy / done / error  out  1 each  playback status.
REQ-016 moves_played  out  5  accepted-move count.
REQ-017 fifo_count  out  5  buffered entries, 0..DEPTH.

Function
REQ-018 Null move = x=0, y=0, dir=0 (off-board corner); driven in every state except WAIT.
REQ-019 States: IDLE, ISSUE, WAIT, GAP, DONE, ERR.
REQ-020 wr_ready = 1 in IDLE/DONE/ERR with fifo_count<DEPTH; write occurs on wr_valid&wr_ready; full -> write dropped, wr_ready 0.
REQ-021 IDLE/DONE/ERR + start: fifo_count==0 -> DONE next cycle; else ISSUE next cycle, moves_played, done and error cleared. start during busy ignored.
REQ-022 Same-cycle write and start: write completes; ISSUE sees the new count.
REQ-023 ISSUE (1 cycle): snapshot piece_count, pop head, drive popped move from next cycle; -> WAIT.
REQ-024 WAIT: piece_count==snap-1 -> moves_played+1 (saturating 31), -> GAP; other change in piece_count -> ERR; TIMEOUT cycles unchanged -> ERR.
REQ-025 GAP: null move for GAP_CYCLES cycles; then game_over or fifo empty -> DONE, else ISSUE.
REQ-026 busy=1 in ISSUE/WAIT/GAP; done=1 in DONE; error=1 in ERR; sticky until start/clear/rst.
REQ-027 clear in any state: fifo emptied, counters zeroed, -> IDLE next cycle; clear beats start and write in the same cycle.
REQ-028 Pointers wrap modulo DEPTH; fifo_count is a separate DEPTH+1-valued counter.

Reset
REQ-029 rst asserted: state IDLE, buffer empty, null move out, busy/done/error 0, moves_played 0, fifo_count 0, wr_ready 1, all regardless of clk.
REQ-030 Reset mid-playback discards in-flight move and buffer; no further move driven until new writes and start.

Structure
REQ-031 solitaire_pkg holds move struct (x, y, direction), NULL_MOVE constant, state enum and parameter defaults.
REQ-032 Buffer is sub-module solitaire_move_fifo (sync write/pop, count, full/empty); FSM and timers stay in the top.

Verification
REQ-033 Reset, 3 writes, start, game model decrements per move 32->29 -> done=1, moves_played=3, fifo_count=0, null move out.
REQ-034 Write 17 moves with DEPTH=16 -> 17th dropped, wr_ready=0 at count 16.
REQ-035 Game model ignores 2nd move -> error=1 exactly TIMEOUT cycles into WAIT, moves_played=1.
REQ-036 game_over asserted after 1st of 4 moves -> DONE after GAP, fifo_count=3.
REQ-037 rst asserted mid-WAIT, not on a clk edge -> outputs at reset values immediately; clear with start same cycle -> IDLE.
REQ-038 start with empty buffer -> done=1 next cycle, no non-null move driven.

Source files
------------

// File: rtl/solitaire_pkg.sv
// Shared types and defaults for the solitaire move autoplayer.
// A move is packed {direction, y, x}, which matches the wr_move port layout bit for bit.
package solitaire_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 16;
    localparam int unsigned DEFAULT_TIMEOUT    = 8;
    localparam int unsigned DEFAULT_GAP_CYCLES = 2;

    typedef struct packed {
        logic [1:0] direction;
        logic [2:0] y;
        logic [2:0] x;
    } move_t;

    // Off-board corner; the game treats it as "no move".
    localparam move_t NULL_MOVE = '{direction: 2'd0, y: 3'd0, x: 3'd0};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StGap,
        StDone,
        StErr
    } state_t;

    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/solitaire_move_fifo.sv
// Move buffer: synchronous write and pop with a first-word-fall-through head.
// The occupancy counter is kept separately from the wrapping pointers, so full is exact.
module solitaire_move_fifo
    import solitaire_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_en,
    input  move_t                        wr_data,
    input  logic                         rd_en,
    output move_t                        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    move_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr;
    logic          do_rd;

    assign count   = count_q;
    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/solitaire_autoplayer.sv
// Plays buffered moves into a peg-solitaire game, one at a time, and judges acceptance
// by watching the game's peg count drop by exactly one.
module solitaire_autoplayer
    import solitaire_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [7:0] wr_move,
    output logic       wr_ready,
    input  logic       start,
    input  logic       clear,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    input  logic [5:0] piece_count,
    input  logic       game_over,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] moves_played,
    output logic [4:0] fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    move_t         move_q, move_d;
    logic [5:0]    snap_q, snap_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [4:0]    played_q, played_d;

    move_t         fifo_head;
    move_t         move_out;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          wr_en;
    logic          accept_state;

    assign accept_state = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
    assign wr_ready     = accept_state && !fifo_full;
    assign wr_en        = wr_valid && wr_ready && !clear;

    solitaire_move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (clear),
        .wr_en   (wr_en),
        .wr_data (move_t'(wr_move)),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            move_q   <= NULL_MOVE;
            snap_q   <= '0;
            wait_q   <= '0;
            gap_q    <= '0;
            played_q <= '0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_d;
            snap_q   <= snap_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            played_q <= played_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        move_d   = move_q;
        snap_d   = snap_q;
        wait_d   = wait_q;
        gap_d    = gap_q;
        played_d = played_q;
        fifo_rd  = 1'b0;

        if (clear) begin
            state_d  = StIdle;
            played_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        played_d = '0;
                        // A write landing in the same cycle counts toward the decision.
                        state_d  = (fifo_empty && !wr_en) ? StDone : StIssue;
                    end
                end
                StIssue: begin
                    snap_d  = piece_count;
                    move_d  = fifo_head;
                    fifo_rd = 1'b1;
                    wait_d  = '0;
                    state_d = StWait;
                end
                StWait: begin
                    if (piece_count == snap_q - 6'd1) begin
                        played_d = sat_inc5(played_q);
                        gap_d    = '0;
                        state_d  = StGap;
                    end else if (piece_count != snap_q) begin
                        state_d = StErr;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = StErr;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = (game_over || fifo_empty) ? StDone : StIssue;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output decode is purely from state so an asynchronous reset reaches the pins at once.
    assign move_out     = (state_q == StWait) ? move_q : NULL_MOVE;
    assign piece_x      = move_out.x;
    assign piece_y      = move_out.y;
    assign direction    = move_out.direction;
    assign busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StGap);
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign moves_played = played_q;
    assign fifo_count   = 5'(fifo_cnt);

endmodule

// File: tb/tb_solitaire_autoplayer.sv
// Randomised bench for solitaire_autoplayer with a small peg-game model and a move scoreboard.
module tb_solitaire_autoplayer;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned TIMEOUT    = 8;
    localparam int unsigned GAP_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_move;
    logic       wr_ready;
    logic       start;
    logic       clear;
    logic [2:0] piece_x;
    logic [2:0] piece_y;
    logic [1:0] direction;
    logic [5:0] piece_count;
    logic       game_over;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] moves_played;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];  // what the buffer should hold, oldest first
    logic [7:0] seen_q[$];   // moves the game model saw driven

    always #5 clk = ~clk;

    solitaire_autoplayer #(
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_move      (wr_move),
        .wr_ready     (wr_ready),
        .start        (start),
        .clear        (clear),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .direction    (direction),
        .piece_count  (piece_count),
        .game_over    (game_over),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .moves_played (moves_played),
        .fifo_count   (fifo_count)
    );

    function automatic logic [7:0] rand_move();
        logic [7:0] m;
        do m = 8'($urandom); while (m == 8'd0);
        return m;
    endfunction

    function automatic logic [7:0] cur_move();
        return {direction, piece_y, piece_x};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_move(input logic [7:0] m);
        checks++;
        if (wr_ready !== (model_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL wr_ready got %b want %b (stored %0d)", wr_ready,
                     model_q.size() < DEPTH, model_q.size());
        end
        wr_valid = 1'b1;
        wr_move  = m;
        tick();
        wr_valid = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(m);
        checks++;
        if (fifo_count !== 5'(model_q.size())) begin
            errors++;
            $display("FAIL fifo_count_after_write got %0d want %0d", fifo_count, model_q.size());
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_q.delete();
    endtask

    // Peg game: accepts each new move after a random latency, unless told to ignore it,
    // to remove two pegs, or to raise game_over after it.
    task automatic play(input int reject_idx, input int drop2_idx, input int over_idx,
                        output int n_seen, output int err_delay, output logic timed_out);
        int          pend;
        int          since;
        logic [7:0]  prev;
        logic [7:0]  mv;
        pend      = -1;
        since     = 0;
        prev      = 8'd0;
        n_seen    = 0;
        err_delay = -1;
        timed_out = 1'b1;
        seen_q.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            mv = cur_move();
            if (mv != 8'd0 && prev == 8'd0) begin
                seen_q.push_back(mv);
                since = 0;
                if (n_seen == reject_idx) begin
                    pend = -1;
                end else if (n_seen == drop2_idx) begin
                    piece_count = piece_count - 6'd2;
                    pend = -1;
                end else begin
                    pend = int'($urandom_range(0, TIMEOUT - 1));
                end
                n_seen++;
            end else begin
                since++;
            end
            if (pend == 0) begin
                piece_count = piece_count - 6'd1;
                if (n_seen - 1 == over_idx) game_over = 1'b1;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            if (done || error) begin
                if (error) err_delay = since;
                timed_out = 1'b0;
                break;
            end
            prev = mv;
            tick();
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL play_timeout got busy=%b want done or error within budget", busy);
        end
    endtask

    task automatic check_order(input string name, input int n_exp);
        int bad;
        bad = 0;
        if (seen_q.size() != n_exp) bad++;
        for (int i = 0; i < n_exp; i++) begin
            if (i >= seen_q.size() || i >= model_q.size()) bad++;
            else if (seen_q[i] !== model_q[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s seen %0d moves (%0d wrong) want %0d in write order",
                     name, seen_q.size(), bad, n_exp);
        end
        for (int i = 0; i < n_exp && model_q.size() > 0; i++) void'(model_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_move = 8'd0; start = 1'b0; clear = 1'b0;
        piece_count = 6'd32; game_over = 1'b0;
        #1;
        checks++;
        if ({busy, done, error} !== 3'b000) begin
            errors++; $display("FAIL reset_status got %b want 000", {busy, done, error});
        end
        checks++;
        if (cur_move() !== 8'd0) begin
            errors++; $display("FAIL reset_move got %h want 00", cur_move());
        end
        checks++;
        if (moves_played !== 5'd0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", moves_played, fifo_count);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_accept_all(input string name, input int n);
        int n_seen, err_delay;
        logic to;
        int exp_n;
        pulse_clear();
        for (int i = 0; i < n; i++) write_move(rand_move());
        exp_n = model_q.size();
        piece_count = 6'd32;
        pulse_start();
        play(-1, -1, -1, n_seen, err_delay, to);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_status got %b want 100 (done,error,busy)", name, {done, error, busy});
        end
        checks++;
        if (moves_played !== 5'((exp_n > 31) ? 31 : exp_n)) begin
            errors++; $display("FAIL %s_played got %0d want %0d", name, moves_played, exp_n);
        end
        checks++;
        if (fifo_count !== 5'd0 || cur_move() !== 8'd0) begin
            errors++;
            $display("FAIL %s_idle_out got count %0d move %h want 0/00", name, fifo_count,
                     cur_move());
        end
        check_order(name, exp_n);
    endtask

    task automatic test_basic();
        run_accept_all("basic3", 3);
        checks++;
        if (piece_count !== 6'd29) begin
            errors++; $display("FAIL basic3_pegs got %0d want 29", piece_count);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) run_accept_all("random", int'($urandom_range(1, DEPTH)));
    endtask

    task automatic test_full();
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) write_move(rand_move());
        checks++;
        if (fifo_count !== 5'(DEPTH) || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got count %0d ready %b want %0d/0", fifo_count, wr_ready,
                     DEPTH);
        end
        write_move(rand_move());
        run_full_playback();
    endtask

    task automatic run_full_playback();
        int n_seen, err_delay;
        logic to;
        piece_count = 6'd40;
        pulse_start();
        play(-1, -1, -1, n_seen, err_delay, to);
        checks++;
        if (moves_played !== 5'(DEPTH) || done !== 1'b1) begin
            errors++;
            $display("FAIL full_played got %0d done %b want %0d/1", moves_played, done, DEPTH);
        end
        check_order("full_order", DEPTH);
    endtask

    task automatic test_reject();
        int n_seen, err_delay;
        logic to;
        pulse_clear();
        for (int i = 0; i < 3; i++) write_move(rand_move());
        piece_count = 6'd32;
        pulse_start();
        play(1, -1, -1, n_seen, err_delay, to);
        checks++;
        if (err_delay !== int'(TIMEOUT)) begin
            errors++; $display("FAIL reject_delay got %0d want %0d", err_delay, TIMEOUT);
        end
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || moves_played !== 5'd1) begin
            errors++;
            $display("FAIL reject_state got err %b done %b busy %b played %0d want 1/0/0/1",
                     error, done, busy, moves_played);
        end
        check_order("reject_order", 2);
        tick(); tick();
        checks++;
        if (error !== 1'b1 || fifo_count !== 5'(model_q.size()) || cur_move() !== 8'd0) begin
            errors++;
            $display("FAIL reject_sticky got err %b count %0d move %h want 1/%0d/00", error,
                     fifo_count, cur_move(), model_q.size());
        end
    endtask

    task automatic test_bad_delta();
        int n_seen, err_delay;
        logic to;
        pulse_clear();
        for (int i = 0; i < 2; i++) write_move(rand_move());
        piece_count = 6'd20;
        pulse_start();
        play(-1, 0, -1, n_seen, err_delay, to);
        checks++;
        if (err_delay !== 1 || error !== 1'b1 || moves_played !== 5'd0) begin
            errors++;
            $display("FAIL bad_delta got delay %0d err %b played %0d want 1/1/0", err_delay,
                     error, moves_played);
        end
    endtask

    task automatic test_game_over();
        int n_seen, err_delay;
        logic to;
        pulse_clear();
        for (int i = 0; i < 4; i++) write_move(rand_move());
        piece_count = 6'd32;
        pulse_start();
        play(-1, -1, 0, n_seen, err_delay, to);
        checks++;
        if (done !== 1'b1 || fifo_count !== 5'd3 || moves_played !== 5'd1) begin
            errors++;
            $display("FAIL game_over got done %b count %0d played %0d want 1/3/1", done,
                     fifo_count, moves_played);
        end
        check_order("game_over_order", 1);
        game_over = 1'b0;
        pulse_start();
        play(-1, -1, -1, n_seen, err_delay, to);
        checks++;
        if (done !== 1'b1 || moves_played !== 5'd3 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL resume got done %b played %0d count %0d want 1/3/0", done,
                     moves_played, fifo_count);
        end
        check_order("resume_order", 3);
    endtask

    task automatic test_empty_start();
        int stray;
        pulse_clear();
        pulse_start();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_start got done %b busy %b want 1/0", done, busy);
        end
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (cur_move() != 8'd0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL empty_start_moves got %0d non-null want 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int n_seen, err_delay;
        logic [7:0] m;
        logic to;
        pulse_clear();
        m = rand_move();
        wr_valid = 1'b1; wr_move = m; start = 1'b1;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        model_q.push_back(m);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL write_start got busy %b want 1", busy);
        end
        piece_count = 6'd10;
        play(-1, -1, -1, n_seen, err_delay, to);
        checks++;
        if (done !== 1'b1 || moves_played !== 5'd1) begin
            errors++;
            $display("FAIL write_start_done got done %b played %0d want 1/1", done, moves_played);
        end
        check_order("write_start_order", 1);
    endtask

    task automatic test_async_reset();
        int stray;
        logic seen;
        pulse_clear();
        for (int i = 0; i < 3; i++) write_move(rand_move());
        piece_count = 6'd32;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cur_move() != 8'd0) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL async_wait got no move want move driven");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cur_move() !== 8'd0 || {busy, done, error} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_out got move %h status %b want 00/000", cur_move(),
                     {busy, done, error});
        end
        checks++;
        if (fifo_count !== 5'd0 || moves_played !== 5'd0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_cnt got %0d/%0d ready %b want 0/0/1", fifo_count,
                     moves_played, wr_ready);
        end
        tick();
        rst = 1'b0;
        model_q.delete();
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cur_move() != 8'd0 || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL post_reset_activity got %0d want 0", stray);
        end
        for (int i = 0; i < 2; i++) write_move(rand_move());
        wr_valid = 1'b1; wr_move = rand_move(); clear = 1'b1; start = 1'b1;
        tick();
        wr_valid = 1'b0; clear = 1'b0; start = 1'b0;
        model_q.delete();
        tick();
        checks++;
        if ({busy, done, error} !== 3'b000 || fifo_count !== 5'd0 || moves_played !== 5'd0) begin
            errors++;
            $display("FAIL clear_beats_start got status %b count %0d want 000/0",
                     {busy, done, error}, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_full();
        test_reject();
        test_bad_delta();
        test_game_over();
        test_empty_start();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
